// File: rtl/osd_overlay_ms_pkg.sv
// ============================================================================
// Package : osd_pkg
// Brief   : Shared types and helpers for the osd_overlay_ms OSD overlay:
//           RGB565 field layout, scale_sel encodings, swap FSM states and
//           the 50% background darkening function.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package osd_pkg;

  // RGB565 pixel split into its colour fields
  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // scale_sel encodings; code 3 is an alias of x1
  typedef enum logic [1:0] {
    SCALE_X1     = 2'd0,
    SCALE_X2     = 2'd1,
    SCALE_X4     = 2'd2,
    SCALE_X1_ALT = 2'd3
  } scale_e;

  // Bank swap FSM
  typedef enum logic {
    SWAP_IDLE = 1'b0,
    SWAP_PEND = 1'b1
  } swap_state_e;

  // Map scale_sel to a left-shift amount (log2 of the magnification)
  function automatic logic [1:0] scale_shift(input logic [1:0] sel);
    case (sel)
      SCALE_X2: return 2'd1;
      SCALE_X4: return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

  // Darken a pixel by halving each colour field independently
  function automatic logic [15:0] blend_half(input logic [15:0] pix);
    rgb565_t p;
    rgb565_t q;
    p   = pix;
    q.r = p.r >> 1;
    q.g = p.g >> 1;
    q.b = p.b >> 1;
    return q;
  endfunction

endpackage

`default_nettype wire

// File: rtl/osd_overlay_ms_if.sv
// ============================================================================
// Interface : osd_overlay_ms_if
// Brief     : Video stream bundle for the OSD overlay: the incoming timing
//             and pixel (i_*) and the delayed, overlaid stream (o_*).
//             master = video source/sink side, slave = overlay block.
// Rev       : 1.0  initial release
// ============================================================================
`default_nettype none

interface osd_overlay_ms_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  i_hs;
  logic                  i_vs;
  logic                  i_de;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  o_hs;
  logic                  o_vs;
  logic                  o_de;
  logic [DATA_WIDTH-1:0] o_data;

  modport master (
    output i_hs, i_vs, i_de, i_data,
    input  o_hs, o_vs, o_de, o_data
  );

  modport slave (
    input  i_hs, i_vs, i_de, i_data,
    output o_hs, o_vs, o_de, o_data
  );
endinterface

`default_nettype wire

// File: rtl/osd_overlay_ms_bitmap_ram.sv
// ============================================================================
// Module : osd_bitmap_ram
// Brief  : Two-bank 1-bpp bitmap store, one write port and one synchronous
//          read port with a registered 1-cycle read latency. Bank and row
//          are concatenated into a single flat address.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module osd_bitmap_ram #(
  parameter int OSD_W = 128,
  parameter int OSD_H = 32,
  parameter int ROW_W = $clog2(OSD_H)
) (
  input  logic             pclk,
  input  logic             wr_en,
  input  logic             wr_bank,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [OSD_W-1:0] wr_bits,
  input  logic             rd_bank,
  input  logic [ROW_W-1:0] rd_row,
  output logic [OSD_W-1:0] rd_word
);

  logic [OSD_W-1:0] r_mem [0:2*OSD_H-1];
  logic [OSD_W-1:0] r_rd_word;

  // Write port plus registered read; contents deliberately not reset
  always_ff @(posedge pclk) begin
    if (wr_en) begin
      r_mem[{wr_bank, wr_row}] <= wr_bits;
    end
    r_rd_word <= r_mem[{rd_bank, rd_row}];
  end

  assign rd_word = r_rd_word;

endmodule

`default_nettype wire

// File: rtl/osd_overlay_ms.sv
// ============================================================================
// Module : osd_overlay_ms
// Brief  : On-screen-display overlay for an RGB565 video stream. Keys a
//          double-buffered 1-bpp bitmap at a runtime origin and scale onto
//          the pixel stream with a fixed 2-cycle latency.
//          Build option OSD_BG_BLEND_EN: background pixels are the input
//          darkened 50% per channel; otherwise they are solid black.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module osd_overlay_ms
  import osd_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int OSD_W      = 128,
  parameter int OSD_H      = 32,
  parameter int COORD_W    = 12,
  parameter int ROW_W      = $clog2(OSD_H)
) (
  input  logic                  pclk,
  input  logic                  rst_n,      // active-high despite the name
  osd_overlay_ms_if.slave       vid,
  input  logic                  osd_en,
  input  logic [COORD_W-1:0]    osd_x0,
  input  logic [COORD_W-1:0]    osd_y0,
  input  logic [1:0]            scale_sel,
  input  logic [DATA_WIDTH-1:0] fg_color,
  input  logic                  bg_en,
  input  logic                  wr_en,
  input  logic [ROW_W-1:0]      wr_row,
  input  logic [OSD_W-1:0]      wr_bits,
  input  logic                  swap_req,
  output logic                  swap_ack,
  output logic                  active_bank
);

  // Region maths is widened by 3 bits so x0 + OSD_W*4 can never wrap
  localparam int                 c_EXT_W   = COORD_W + 3;
  localparam int                 c_COL_W   = $clog2(OSD_W);
  localparam logic [c_COL_W-1:0] c_COL_MAX = c_COL_W'(OSD_W - 1);
  localparam logic [c_EXT_W-1:0] c_SPAN_W  = c_EXT_W'(OSD_W);
  localparam logic [c_EXT_W-1:0] c_SPAN_H  = c_EXT_W'(OSD_H);

  logic                  r_vs_d, r_de_d;
  logic [COORD_W-1:0]    r_x, r_y;
  logic                  r_sh_en, r_sh_bg;
  logic [COORD_W-1:0]    r_sh_x0, r_sh_y0;
  logic [1:0]            r_sh_shift;
  logic [DATA_WIDTH-1:0] r_sh_fg;
  swap_state_e           r_state;
  logic                  r_active_bank, r_swap_ack;
  logic                  r_s1_hs, r_s1_vs, r_s1_de, r_s1_region, r_s1_bg;
  logic [DATA_WIDTH-1:0] r_s1_data, r_s1_fg;
  logic [c_COL_W-1:0]    r_s1_col;
  logic                  r_o_hs, r_o_vs, r_o_de;
  logic [DATA_WIDTH-1:0] r_o_data;

  logic                  w_fs, w_de_fall, w_region, w_bit, w_wr_bank;
  logic [c_EXT_W-1:0]    w_x, w_y, w_x0, w_y0, w_dx, w_dy, w_x_end, w_y_end;
  logic [c_COL_W-1:0]    w_col;
  logic [ROW_W-1:0]      w_row;
  logic [OSD_W-1:0]      w_rd_word;
  logic [DATA_WIDTH-1:0] w_bg_pix, w_pix;

  assign w_fs      = vid.i_vs & ~r_vs_d;
  assign w_de_fall = ~vid.i_de & r_de_d;

  assign w_x     = c_EXT_W'(r_x);
  assign w_y     = c_EXT_W'(r_y);
  assign w_x0    = c_EXT_W'(r_sh_x0);
  assign w_y0    = c_EXT_W'(r_sh_y0);
  assign w_x_end = w_x0 + (c_SPAN_W << r_sh_shift);
  assign w_y_end = w_y0 + (c_SPAN_H << r_sh_shift);
  assign w_dx    = w_x - w_x0;
  assign w_dy    = w_y - w_y0;
  assign w_col   = c_COL_W'(w_dx >> r_sh_shift);
  assign w_row   = ROW_W'(w_dy >> r_sh_shift);
  assign w_region = r_sh_en && (w_x >= w_x0) && (w_x < w_x_end)
                            && (w_y >= w_y0) && (w_y < w_y_end);

  // Software always writes the bank that is not on screen
  assign w_wr_bank = ~r_active_bank;

  osd_bitmap_ram #(
    .OSD_W (OSD_W),
    .OSD_H (OSD_H),
    .ROW_W (ROW_W)
  ) u_ram (
    .pclk    (pclk),
    .wr_en   (wr_en),
    .wr_bank (w_wr_bank),
    .wr_row  (wr_row),
    .wr_bits (wr_bits),
    .rd_bank (r_active_bank),
    .rd_row  (w_row),
    .rd_word (w_rd_word)
  );

  // Sync edge history and raster x/y counters
  always_ff @(posedge pclk) begin
    if (rst_n) begin
      r_vs_d <= 1'b0;
      r_de_d <= 1'b0;
      r_x    <= '0;
      r_y    <= '0;
    end else begin
      r_vs_d <= vid.i_vs;
      r_de_d <= vid.i_de;
      if (vid.i_de) begin
        r_x <= r_x + 1'b1;
      end else if (w_de_fall) begin
        r_x <= '0;
      end
      if (w_fs) begin
        r_y <= '0;
      end else if (w_de_fall) begin
        r_y <= r_y + 1'b1;
      end
    end
  end

  // Overlay settings are frozen for a whole frame, sampled at frame start
  always_ff @(posedge pclk) begin
    if (rst_n) begin
      r_sh_en    <= 1'b0;
      r_sh_bg    <= 1'b0;
      r_sh_x0    <= '0;
      r_sh_y0    <= '0;
      r_sh_shift <= 2'd0;
      r_sh_fg    <= '0;
    end else if (w_fs) begin
      r_sh_en    <= osd_en;
      r_sh_bg    <= bg_en;
      r_sh_x0    <= osd_x0;
      r_sh_y0    <= osd_y0;
      r_sh_shift <= scale_shift(scale_sel);
      r_sh_fg    <= fg_color;
    end
  end

  // Bank swap FSM: a request is parked until the next frame start
  always_ff @(posedge pclk) begin
    if (rst_n) begin
      r_state       <= SWAP_IDLE;
      r_active_bank <= 1'b0;
      r_swap_ack    <= 1'b0;
    end else begin
      r_swap_ack <= 1'b0;
      case (r_state)
        SWAP_IDLE: begin
          if (swap_req) r_state <= SWAP_PEND;
        end
        SWAP_PEND: begin
          if (w_fs) begin
            r_state       <= SWAP_IDLE;
            r_active_bank <= ~r_active_bank;
            r_swap_ack    <= 1'b1;
          end
        end
        default: r_state <= SWAP_IDLE;
      endcase
    end
  end

  // Stage 1: region decision, bitmap column, delayed sync/pixel
  always_ff @(posedge pclk) begin
    if (rst_n) begin
      r_s1_hs     <= 1'b0;
      r_s1_vs     <= 1'b0;
      r_s1_de     <= 1'b0;
      r_s1_data   <= '0;
      r_s1_region <= 1'b0;
      r_s1_col    <= '0;
      r_s1_bg     <= 1'b0;
      r_s1_fg     <= '0;
    end else begin
      r_s1_hs     <= vid.i_hs;
      r_s1_vs     <= vid.i_vs;
      r_s1_de     <= vid.i_de;
      r_s1_data   <= vid.i_data;
      r_s1_region <= w_region;
      r_s1_col    <= w_col;
      r_s1_bg     <= r_sh_bg;
      r_s1_fg     <= r_sh_fg;
    end
  end

  assign w_bit = w_rd_word[c_COL_MAX - r_s1_col];

`ifdef OSD_BG_BLEND_EN
  assign w_bg_pix = DATA_WIDTH'(blend_half(16'(r_s1_data)));
`else
  assign w_bg_pix = '0;
`endif

  // Pixel select: set bit -> foreground, clear bit -> optional background
  always_comb begin
    w_pix = r_s1_data;
    if (r_s1_region) begin
      if (w_bit) begin
        w_pix = r_s1_fg;
      end else if (r_s1_bg) begin
        w_pix = w_bg_pix;
      end
    end
  end

  // Stage 2: registered outputs, all four kept in step
  always_ff @(posedge pclk) begin
    if (rst_n) begin
      r_o_hs   <= 1'b0;
      r_o_vs   <= 1'b0;
      r_o_de   <= 1'b0;
      r_o_data <= '0;
    end else begin
      r_o_hs   <= r_s1_hs;
      r_o_vs   <= r_s1_vs;
      r_o_de   <= r_s1_de;
      r_o_data <= w_pix;
    end
  end

  assign vid.o_hs     = r_o_hs;
  assign vid.o_vs     = r_o_vs;
  assign vid.o_de     = r_o_de;
  assign vid.o_data   = r_o_data;
  assign swap_ack     = r_swap_ack;
  assign active_bank  = r_active_bank;

endmodule

`default_nettype wire

// File: doc/osd_overlay_ms.md
# osd_overlay_ms

Parametrised on-screen-display overlay for the HDMI video path. It sits between the timing source and the HDMI encoder on the pixel clock. It keys a one-bit-per-pixel text/graphics bitmap onto the incoming RGB565 stream, with these features:
- runtime position and integer scale;
- solid foreground colour and optional background keying;
- a double-buffered bitmap, so software-side updates never tear mid-frame.

## Interface
Parameters:
- DATA_WIDTH, 16, pixel width (RGB565)
- OSD_W, 128, bitmap width in pixels (bits per row word)
- OSD_H, 32, bitmap height in rows
- COORD_W, 12, width of x/y counters and origin inputs
- ROW_W, $clog2(OSD_H), derived row-address width

Ports:
- pclk  in  1  pixel clock, sole clock
- rst_n  in  1  synchronous, active-high reset (asserted = 1)
- i_hs / i_vs / i_de  in  1 each  input sync and data-enable, active-high
- i_data  in  DATA_WIDTH  input pixel
- o_hs / o_vs / o_de  out  1 each  delayed sync and data-enable
- o_data  out  DATA_WIDTH  overlaid pixel
- osd_en  in  1  overlay enable
- osd_x0, osd_y0  in  COORD_W  top-left origin
- scale_sel  in  2  0:x1, 1:x2, 2:x4, 3:x1
- fg_color  in  DATA_WIDTH  colour for set bits
- bg_en  in  1  apply background treatment to clear bits inside region
- wr_en  in  1  bitmap row write strobe
- wr_row  in  ROW_W  row to write
- wr_bits  in  OSD_W  row data; MSB is the leftmost pixel
- swap_req  in  1  request bank swap at next frame start
- swap_ack  out  1  one-cycle pulse when the swap executes
- active_bank  out  1  bank currently displayed

## Operation
- Frame start (FS) is the cycle where i_vs is 1 and was 0 on the previous cycle.
- Counters:
  - x increments on each i_de=1 cycle and clears on i_de falling.
  - y increments on i_de falling and clears at FS.
- Shadow registers: osd_en, osd_x0, osd_y0, scale_sel, fg_color and bg_en are captured only at FS. Mid-frame input changes take effect next frame.
- Scale: s = 1<<sh, where sh = 0/1/2 per scale_sel.
- Region:
  - x0 <= x < x0 + OSD_W*s and y0 <= y < y0 + OSD_H*s.
  - Compare in COORD_W+3 bits, so the region never wraps; it clips at the counter maximum.
- Lookup: col = (x-x0)>>sh, row = (y-y0)>>sh, bit = word[row][OSD_W-1-col].
- Pixel rule, in region with shadow osd_en = 1:
  - bit 1 → fg_color.
  - bit 0 and bg_en 1 → background treatment (see Configuration).
  - otherwise → i_data.
- Outside the region, or with osd_en = 0, i_data passes unchanged.
- Banks: two banks of OSD_H×OSD_W.
  - Writes always target bank ~active_bank, as sampled in the same cycle.
  - Reads always use active_bank.
- Swap FSM, states IDLE and PEND:
  - IDLE → PEND on swap_req.
  - PEND → IDLE at FS: toggle active_bank and pulse swap_ack.
  - swap_req asserted in the FS cycle while in IDLE → PEND; it swaps at the following FS.
  - swap_req while in PEND is absorbed.
- Reset:
  - o_hs, o_vs, o_de, o_data, swap_ack and active_bank = 0; FSM = IDLE; counters = 0; shadow osd_en = 0.
  - Bitmap contents are undefined after reset.
- Reset mid-frame: outputs return to 0 next cycle. Overlay stays off until the first FS after release.

## Timing
- Fixed latency of 2 pclk from i_* to o_*. All four outputs stay mutually aligned, including outside the region.
- Pipeline:
  - Stage 1 registers region flag, col, and RAM read address.
  - Stage 2 registers RAM word select and the pixel mux.
- A write at cycle n is visible to reads of that bank from n+1. Writing the active bank is impossible by construction.
- swap_ack is asserted in the cycle after FS is detected; active_bank changes in that same cycle.

## Configuration
- OSD_BG_BLEND_EN defined: background pixels are the input darkened 50% per channel: {r>>1, g>>1, b>>1} on the 5/6/5 fields.
- Undefined: background pixels are solid 16'h0000. No blend logic is synthesised.

## Structure
- Package osd_pkg:
  - RGB565 field typedef.
  - scale_sel encodings.
  - swap FSM state enum.
  - blend function.
- Sub-module osd_bitmap_ram: two-bank, one write port and one synchronous read port; registered read with 1-cycle latency.

## Test plan
- Reset, then 1920×1080 timing, osd_en=0 → o_data equals i_data delayed 2 cycles, and o_hs/o_vs/o_de are aligned.
- Write row 0 = MSB-only into bank 1, swap_req, x0=100, y0=50, scale x1 → swap_ack at next FS; pixel (100,50) = fg_color, (101,50) = input.
- scale_sel=2, row 0 MSB set → 4×4 block at (100..103, 50..53) = fg_color; (104,50) = input.
- bg_en=1, bit 0 in region, input 16'hFFFF → 16'h7BEF with OSD_BG_BLEND_EN, 16'h0000 without.
- Change osd_x0 mid-frame → the current frame is unchanged; the new position applies from the next FS.
- swap_req exactly on the FS cycle, plus wr_en in the swap cycle → swap happens at the following FS; the write lands in the pre-swap inactive bank.
